// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for the bit-serial adder.
// The master issues operands on start; the slave reports the result on done.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             carry_in;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;

    modport master (
        output start, A, B, carry_in,
        input  ready, done, sum, carry_out, overflow
    );

    modport slave (
        input  start, A, B, carry_in,
        output ready, done, sum, carry_out, overflow
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice and a carry flop.
// Produces A+B+carry_in LSB first over WIDTH cycles.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input logic           clk,
    input logic           rst,
    serial_adder_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             c;
    logic             done_r;
    logic             cout_r;
    logic             ovf_r;
    logic             s;
    logic             c_nx;
    logic             last;
    logic             accept;

    always_comb begin
        s    = a_sh[0] ^ b_sh[0] ^ c;
        c_nx = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
    end

    assign last   = (cnt == CW'(WIDTH - 1));
    assign accept = (state == IDLE) && bus.start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.start) state_nx = RUN;
            RUN:     if (last)      state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res    <= '0;
            cnt    <= '0;
            c      <= 1'b0;
            done_r <= 1'b0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (accept) begin
                a_sh   <= bus.A;
                b_sh   <= bus.B;
                c      <= bus.carry_in;
                cnt    <= '0;
                res    <= '0;
                cout_r <= 1'b0;
                ovf_r  <= 1'b0;
            end else if (state == RUN) begin
                // Sum bits enter at the MSB so the word ends LSB-aligned.
                res  <= {s, res[WIDTH-1:1]};
                a_sh <= a_sh >> 1;
                b_sh <= b_sh >> 1;
                c    <= c_nx;
                if (last) begin
                    cout_r <= c_nx;
                    ovf_r  <= c ^ c_nx;
                    done_r <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign bus.ready     = (state == IDLE);
    assign bus.done      = done_r;
    assign bus.sum       = res;
    assign bus.carry_out = cout_r;
    assign bus.overflow  = ovf_r;
endmodule
